// File: rtl/serial_link_pkg.sv
// Shared types and constants for the CPU <-> Arduino bit-serial memory link.
// Frame layout: 2-bit cmd, 16-bit address, optional 16-bit write data.
package serial_link_pkg;

  localparam int WORD_W  = 16;
  localparam int CMD_W   = 2;
  localparam int FRAME_W = CMD_W + 2 * WORD_W;
  localparam int CNT_W   = 6;

  localparam logic [CMD_W-1:0] CMD_READ  = 2'b01;
  localparam logic [CMD_W-1:0] CMD_WRITE = 2'b10;

  // Running bit count at the last bit of each phase
  localparam logic [CNT_W-1:0] LAST_CMD   = 6'd1;
  localparam logic [CNT_W-1:0] LAST_ADDR  = 6'd17;
  localparam logic [CNT_W-1:0] LAST_WDATA = 6'd33;
  localparam logic [CNT_W-1:0] LAST_RECV  = 6'd33;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_ADDR,
    S_WDATA,
    S_RECV,
    S_DONE
  } state_e;

  typedef enum logic {
    OWN_FETCH,
    OWN_MEM
  } owner_e;

  typedef struct packed {
    owner_e owner;
    logic   we;
  } link_req_t;

  function automatic logic [FRAME_W-1:0] make_frame(
    input logic              we,
    input logic [WORD_W-1:0] addr,
    input logic [WORD_W-1:0] wdata
  );
    return {we ? CMD_WRITE : CMD_READ, addr, wdata};
  endfunction

endpackage

// File: rtl/link_shifter.sv
// 34-bit PISO for outgoing frames, SIPO for read data, and a shared
// bit counter that runs across the outgoing and incoming phases.
module link_shifter
  import serial_link_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load_i,
  input  logic [FRAME_W-1:0] frame_i,
  input  logic               shift_i,
  input  logic               rx_i,
  input  logic               ser_in_i,
  output logic               msb_o,
  output logic [CNT_W-1:0]   cnt_o,
  output logic [WORD_W-1:0]  rx_next_o
);

  logic [FRAME_W-1:0] piso_q, piso_d;
  logic [WORD_W-2:0]  sipo_q, sipo_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  assign msb_o     = piso_q[FRAME_W-1];
  assign cnt_o     = cnt_q;
  assign rx_next_o = {sipo_q, ser_in_i};

  always_comb begin
    piso_d = piso_q;
    sipo_d = sipo_q;
    cnt_d  = cnt_q;
    if (load_i) begin
      piso_d = frame_i;
      cnt_d  = '0;
    end else if (shift_i) begin
      piso_d = {piso_q[FRAME_W-2:0], 1'b0};
      cnt_d  = cnt_q + 1'b1;
    end else if (rx_i) begin
      sipo_d = rx_next_o[WORD_W-2:0];
      cnt_d  = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      piso_q <= '0;
      sipo_q <= '0;
      cnt_q  <= '0;
    end else begin
      piso_q <= piso_d;
      sipo_q <= sipo_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/serial_mem_link.sv
// Round-robin arbiter and sequencer for the single serial memory link;
// grants fetch or load/store, sends the frame, collects read data.
module serial_mem_link
  import serial_link_pkg::*;
#(
  parameter int TIMEOUT = 1023
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_req,
  input  logic [WORD_W-1:0] fetch_addr,
  output logic              fetch_gnt,
  output logic              fetch_done,
  output logic [WORD_W-1:0] fetch_data,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [WORD_W-1:0] mem_addr,
  input  logic [WORD_W-1:0] mem_wdata,
  output logic              mem_gnt,
  output logic              mem_done,
  output logic [WORD_W-1:0] mem_rdata,
  output logic              err,
  output logic              ser_out,
  output logic              ser_out_valid,
  input  logic              ard_receive_ready,
  input  logic              ser_in,
  input  logic              ard_data_ready,
  output logic              busy
);

  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST =
    WAIT_W'(TIMEOUT - 1);

  state_e            state_q, state_d;
  owner_e            last_q, last_d;
  link_req_t         req_q, req_d;
  logic              fgnt_q, fgnt_d;
  logic              mgnt_q, mgnt_d;
  logic              err_q, err_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [WORD_W-1:0] fdata_q, fdata_d;
  logic [WORD_W-1:0] mdata_q, mdata_d;

  logic               load, xfer, rx_en, upd;
  logic               pick_mem, pick_fetch;
  logic [FRAME_W-1:0] frame;
  logic [WORD_W-1:0]  rd, rx_next;
  logic [CNT_W-1:0]   cnt;
  logic               msb;

  link_shifter u_shift (
    .clk       (clk),
    .rst       (rst),
    .load_i    (load),
    .frame_i   (frame),
    .shift_i   (xfer),
    .rx_i      (rx_en),
    .ser_in_i  (ser_in),
    .msb_o     (msb),
    .cnt_o     (cnt),
    .rx_next_o (rx_next)
  );

  assign ser_out_valid = (state_q == S_CMD) ||
                         (state_q == S_ADDR) ||
                         (state_q == S_WDATA);
  assign ser_out = ser_out_valid & msb;
  assign xfer    = ser_out_valid & ard_receive_ready;
  assign busy    = (state_q != S_IDLE);

  assign fetch_gnt  = fgnt_q;
  assign mem_gnt    = mgnt_q;
  assign fetch_done = (state_q == S_DONE) &&
                      (req_q.owner == OWN_FETCH);
  assign mem_done   = (state_q == S_DONE) &&
                      (req_q.owner == OWN_MEM);
  assign err        = err_q && (state_q == S_DONE);
  assign fetch_data = fdata_q;
  assign mem_rdata  = mdata_q;

  // Mutually exclusive: on a tie the non-last requester wins
  assign pick_mem   = mem_req &
                      (~fetch_req | (last_q == OWN_FETCH));
  assign pick_fetch = fetch_req &
                      (~mem_req | (last_q == OWN_MEM));

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    req_d   = req_q;
    fgnt_d  = 1'b0;
    mgnt_d  = 1'b0;
    err_d   = err_q;
    wait_d  = wait_q;
    fdata_d = fdata_q;
    mdata_d = mdata_q;
    load    = 1'b0;
    rx_en   = 1'b0;
    upd     = 1'b0;
    rd      = '0;
    frame   = '0;
    unique case (state_q)
      S_IDLE: begin
        err_d = 1'b0;
        unique case (1'b1)
          pick_mem: begin
            frame   = make_frame(mem_we, mem_addr,
                                 mem_wdata);
            req_d   = '{owner: OWN_MEM, we: mem_we};
            last_d  = OWN_MEM;
            mgnt_d  = 1'b1;
            load    = 1'b1;
            state_d = S_CMD;
          end
          pick_fetch: begin
            frame   = make_frame(1'b0, fetch_addr, '0);
            req_d   = '{owner: OWN_FETCH, we: 1'b0};
            last_d  = OWN_FETCH;
            fgnt_d  = 1'b1;
            load    = 1'b1;
            state_d = S_CMD;
          end
          default: ;
        endcase
      end
      S_CMD: begin
        if (xfer && cnt == LAST_CMD) state_d = S_ADDR;
      end
      S_ADDR: begin
        if (xfer && cnt == LAST_ADDR) begin
          state_d = req_q.we ? S_WDATA : S_RECV;
          wait_d  = '0;
        end
      end
      S_WDATA: begin
        if (xfer && cnt == LAST_WDATA) state_d = S_DONE;
      end
      S_RECV: begin
        if (ard_data_ready) begin
          rx_en  = 1'b1;
          wait_d = '0;
          if (cnt == LAST_RECV) begin
            state_d = S_DONE;
            rd      = rx_next;
            upd     = 1'b1;
          end
        end else if (wait_q == WAIT_LAST) begin
          state_d = S_DONE;
          err_d   = 1'b1;
          upd     = 1'b1;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (upd) begin
      if (req_q.owner == OWN_MEM) mdata_d = rd;
      else                        fdata_d = rd;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      last_q  <= OWN_FETCH;
      req_q   <= '{owner: OWN_FETCH, we: 1'b0};
      fgnt_q  <= 1'b0;
      mgnt_q  <= 1'b0;
      err_q   <= 1'b0;
      wait_q  <= '0;
      fdata_q <= '0;
      mdata_q <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      req_q   <= req_d;
      fgnt_q  <= fgnt_d;
      mgnt_q  <= mgnt_d;
      err_q   <= err_d;
      wait_q  <= wait_d;
      fdata_q <= fdata_d;
      mdata_q <= mdata_d;
    end
  end

endmodule

// File: tb/tb_serial_mem_link.sv
// Directed bench for serial_mem_link: table of transactions plus
// hand-written arbitration and mid-transaction reset sequences.
module tb_serial_mem_link;
  import serial_link_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_req;
  logic [15:0] fetch_addr;
  logic        fetch_gnt, fetch_done;
  logic [15:0] fetch_data;
  logic        mem_req, mem_we;
  logic [15:0] mem_addr, mem_wdata;
  logic        mem_gnt, mem_done;
  logic [15:0] mem_rdata;
  logic        err, ser_out, ser_out_valid;
  logic        ard_receive_ready, ser_in, ard_data_ready;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  serial_mem_link #(.TIMEOUT(8)) dut (
    .clk               (clk),
    .rst               (rst),
    .fetch_req         (fetch_req),
    .fetch_addr        (fetch_addr),
    .fetch_gnt         (fetch_gnt),
    .fetch_done        (fetch_done),
    .fetch_data        (fetch_data),
    .mem_req           (mem_req),
    .mem_we            (mem_we),
    .mem_addr          (mem_addr),
    .mem_wdata         (mem_wdata),
    .mem_gnt           (mem_gnt),
    .mem_done          (mem_done),
    .mem_rdata         (mem_rdata),
    .err               (err),
    .ser_out           (ser_out),
    .ser_out_valid     (ser_out_valid),
    .ard_receive_ready (ard_receive_ready),
    .ser_in            (ser_in),
    .ard_data_ready    (ard_data_ready),
    .busy              (busy)
  );

  typedef struct {
    bit          is_mem;
    bit          we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rx;
    bit          tog;
    int          gap;
    logic [15:0] exp_data;
    bit          exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h",
               name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    fetch_req = 0; fetch_addr = '0;
    mem_req = 0; mem_we = 0;
    mem_addr = '0; mem_wdata = '0;
    ard_receive_ready = 0; ser_in = 0;
    ard_data_ready = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic apply_vec(input vec_t v, input string tag);
    logic [33:0] frame = '0;
    logic [33:0] exp_frame;
    int nbits = 0, cyc = 0, gcyc = -1, lat = -1;
    int rxidx = 0, gapc = 0, other = 0;
    bit done = 0;
    logic [15:0] data = '0;
    logic e = 0;
    gapc = v.gap;
    @(negedge clk);
    if (v.is_mem) begin
      mem_req = 1; mem_we = v.we;
      mem_addr = v.addr; mem_wdata = v.wdata;
    end else begin
      fetch_req = 1; fetch_addr = v.addr;
    end
    while (!done && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (v.is_mem ? mem_gnt : fetch_gnt) gcyc = cyc;
      if (v.is_mem ? (fetch_gnt | fetch_done)
                   : (mem_gnt | mem_done)) other++;
      if (v.is_mem ? mem_done : fetch_done) begin
        done = 1;
        lat  = cyc - gcyc;
        data = v.is_mem ? mem_rdata : fetch_data;
        e    = err;
        fetch_req = 0; mem_req = 0;
        ard_data_ready = 0; ard_receive_ready = 0;
      end else begin
        ard_data_ready = 0;
        if (!v.we && nbits == 18 && rxidx < 16) begin
          if (v.gap >= 0 && gapc >= v.gap) begin
            ard_data_ready = 1;
            ser_in = v.rx[15-rxidx];
            rxidx++;
            gapc = 0;
          end else begin
            gapc++;
          end
        end
        ard_receive_ready = v.tog ? cyc[0] : 1'b1;
        if (ser_out_valid && ard_receive_ready) begin
          frame = {frame[32:0], ser_out};
          nbits++;
        end
      end
    end
    exp_frame = v.we ? {CMD_WRITE, v.addr, v.wdata}
                     : {16'h0, CMD_READ, v.addr};
    chk({tag, "_done"}, done, 1'b1);
    chk({tag, "_nbits"}, nbits, v.we ? 34 : 18);
    chk({tag, "_frame"}, frame, exp_frame);
    chk({tag, "_lat"}, lat, v.exp_lat);
    chk({tag, "_err"}, e, v.exp_err);
    chk({tag, "_other"}, other, 0);
    if (!v.we) chk({tag, "_data"}, data, v.exp_data);
  endtask

  initial begin
    logic [1:0] order[4];
    int ng, lowrun, cyc;
    bit fd;
    vec_t fresh;

    vecs[0] = '{0, 0, 16'h1234, 16'h0000, 16'hBEEF,
                0, 0, 16'hBEEF, 0, 34};
    vecs[1] = '{1, 1, 16'h00FF, 16'hA5A5, 16'h0000,
                1, 0, 16'h0000, 0, 67};
    vecs[2] = '{1, 0, 16'h8001, 16'h0000, 16'h5A3C,
                0, 3, 16'h5A3C, 0, 79};
    vecs[3] = '{1, 0, 16'h0F0F, 16'h0000, 16'h0000,
                0, -1, 16'h0000, 1, 26};
    vecs[4] = '{0, 0, 16'hFFFF, 16'h0000, 16'h0001,
                1, 1, 16'h0001, 0, 66};

    do_reset();
    chk("rst_ctrl",
        {fetch_gnt, fetch_done, mem_gnt, mem_done,
         err, ser_out, ser_out_valid, busy}, 8'h00);
    chk("rst_fdata", fetch_data, 16'h0);
    chk("rst_mdata", mem_rdata, 16'h0);

    for (int i = 0; i < 5; i++)
      apply_vec(vecs[i], $sformatf("v%0d", i));

    // both requests in the same cycle after reset
    do_reset();
    @(negedge clk);
    fetch_req = 1; fetch_addr = 16'h0100;
    mem_req = 1; mem_we = 1;
    mem_addr = 16'h0200; mem_wdata = 16'h55AA;
    ard_receive_ready = 1; ard_data_ready = 1; ser_in = 1;
    ng = 0; lowrun = 0; cyc = 0;
    while (ng < 4 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (!busy) lowrun++;
      if (fetch_gnt || mem_gnt) begin
        order[ng] = {fetch_gnt, mem_gnt};
        if (ng > 0)
          chk($sformatf("arb_idle%0d", ng), lowrun, 1);
        lowrun = 0;
        ng++;
      end
    end
    fetch_req = 0; mem_req = 0;
    chk("arb_count", ng, 4);
    chk("arb_order", {order[0], order[1], order[2], order[3]},
        {2'b01, 2'b10, 2'b01, 2'b10});
    fd = 0;
    for (int i = 0; i < 100 && !fd; i++) begin
      @(negedge clk);
      if (fetch_done) fd = 1;
    end
    chk("arb_drop_done", fd, 1'b1);
    chk("arb_fdata", fetch_data, 16'hFFFF);
    ard_data_ready = 0;
    @(negedge clk);

    // reset during ADDR abandons the transaction
    fetch_req = 1; fetch_addr = 16'h4321;
    ard_receive_ready = 1;
    repeat (6) @(negedge clk);
    chk("mid_busy", busy, 1'b1);
    rst = 1; fetch_req = 0;
    @(negedge clk);
    rst = 0;
    chk("mid_ctrl",
        {fetch_gnt, fetch_done, mem_gnt, mem_done,
         err, ser_out, ser_out_valid, busy}, 8'h00);
    chk("mid_fdata", fetch_data, 16'h0);
    fd = 0;
    repeat (40) begin
      @(negedge clk);
      if (fetch_done || mem_done || busy) fd = 1;
    end
    chk("mid_quiet", fd, 1'b0);
    fresh = '{0, 0, 16'h0001, 16'h0000, 16'h1357,
              0, 0, 16'h1357, 0, 34};
    apply_vec(fresh, "fresh");

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_mem_link.md
# serial_mem_link

Arbitrating sequencer for the single bit-serial link between the CPU and the Arduino-hosted memory. Accepts word requests from the instruction-fetch path and the load/store path, grants one at a time, serializes command/address/data out, and deserializes read data back in. Sits between the main control FSM and the external link pins; it is the only block that drives the link.

## Interface
- `TIMEOUT`, default 1023: maximum cycles to wait for a read-data bit before aborting.
- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `fetch_req` in 1: fetch request; held until `fetch_done`.
- `fetch_addr` in 16: fetch word address.
- `fetch_gnt` out 1: one-cycle pulse when the fetch request is captured.
- `fetch_done` out 1: one-cycle completion pulse.
- `fetch_data` out 16: fetched word, valid with `fetch_done` and held afterwards.
- `mem_req` in 1: data request; held until `mem_done`.
- `mem_we` in 1: 1 = store, 0 = load.
- `mem_addr` in 16, `mem_wdata` in 16: data address and store data.
- `mem_gnt` out 1, `mem_done` out 1: as for fetch.
- `mem_rdata` out 16: load result, valid with `mem_done` and held afterwards.
- `err` out 1: high with a `*_done` pulse if that read timed out.
- `ser_out` out 1: outgoing bit; 0 when `ser_out_valid` is 0.
- `ser_out_valid` out 1: outgoing bit presented.
- `ard_receive_ready` in 1: Arduino accepts the presented bit this cycle.
- `ser_in` in 1: incoming bit.
- `ard_data_ready` in 1: `ser_in` valid this cycle.
- `busy` out 1: high in every state except IDLE.

## Operation
- Frame, MSB first: 2-bit cmd (read 01, write 10), 16 address bits, then 16 data bits for a write. A read is followed by 16 response bits.
- Outgoing bit is transferred on a cycle with `ser_out_valid & ard_receive_ready`. Otherwise the bit and counter hold.
- Incoming bit is accepted on a cycle with `ard_data_ready` in RECV only. It is ignored in all other states.
- Arbitration is round-robin on a last-winner flag, which resets to "fetch". When both requests are high, the non-last requester wins. A single request wins immediately.
- States:
  - IDLE: on a winning request, capture addr/wdata/we, pulse the matching gnt, load the cmd, and go to CMD.
  - CMD: send 2 bits, then go to ADDR.
  - ADDR: send 16 bits, then go to WDATA (write) or RECV (read).
  - WDATA: send 16 bits, then go to DONE.
  - RECV: shift in 16 bits. If the wait counter reaches `TIMEOUT` with no accepted bit, set err and go to DONE.
  - DONE: pulse the owner's done (plus err if set). For a read, update the owner's data register (0x0000 on timeout). Then go to IDLE.
- The wait counter resets on every accepted bit and on entry to RECV.
- `err` is cleared in IDLE.
- Reset:
  - all outputs 0, state IDLE, data registers 0x0000, last-winner = fetch.
  - A reset mid-transaction abandons it with no done pulse. The requester re-presents its request.

## Timing
- Request high at posedge N (IDLE): gnt high in cycle N+1, and the first cmd bit is presented in cycle N+1.
- With `ard_receive_ready` held high:
  - write: 34 bit cycles, then `mem_done` on the next cycle. Total 35 cycles from gnt.
  - read: 18 bit cycles, then RECV. Done comes one cycle after the 16th accepted bit.
- The earliest next grant is the cycle after DONE; IDLE lasts at least one cycle.
- A request dropped before gnt is not served. A request dropped after gnt does not abort the transaction.

## Structure
- `serial_link_pkg` holds: `CMD_READ`/`CMD_WRITE` constants, the state enum, `WORD_W = 16`, `CMD_W = 2`, and the owner enum (`OWN_FETCH`, `OWN_MEM`).
- Sub-module `link_shifter` holds the 34-bit PISO load/shift plus the 16-bit SIPO, with a bit counter. The FSM, arbiter and timeout counter live in the top level.

## Test plan
- Fetch read of 0x1234 with ready high: `ser_out` sequence is 01 then 0001001000110100 over 18 valid cycles. Drive 0xBEEF on `ser_in` → `fetch_done` pulse, `fetch_data` = 0xBEEF, `err` = 0.
- Store of 0xA5A5 to 0x00FF with `ard_receive_ready` toggling every cycle: 34 bits, each held while not ready → `mem_done` pulses once, no `fetch_*` activity.
- After reset, `fetch_req` and `mem_req` rise in the same cycle: mem is served first, then fetch. With both re-requested the order alternates, and `busy` has exactly one low cycle between transactions.
- Load with `ard_data_ready` never asserted and `TIMEOUT` = 8: `mem_done` and `err` pulse on the cycle after the 8th idle cycle, with `mem_rdata` = 0x0000.
- `rst` pulsed during ADDR: the next cycle shows all outputs 0, no done pulse, and `busy` = 0. A fresh fetch of 0x0001 then completes normally.
- Read with `ard_data_ready` gaps of 3 cycles between bits (`TIMEOUT` = 8): completes with correct data and `err` = 0.
